// File: rtl/julia_iter.sv
// julia_iter: iterates z = z^2 + c per pixel and reports the escape count; define JULIA_SAT_EN to saturate z updates.
module julia_iter #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10,
  parameter int FRAC_BITS  = 12,
  parameter int X_OFFSET   = 320,
  parameter int Y_OFFSET   = 240,
  parameter int STEP_SHIFT = 8,
  parameter int MAX_ITER   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_X_BITS-1:0] x_value,
  input  logic [NUM_Y_BITS-1:0] y_value,
  input  logic [15:0]           c_re,
  input  logic [15:0]           c_im,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [7:0]            iter_count,
  output logic [NUM_X_BITS-1:0] pix_x,
  output logic [NUM_Y_BITS-1:0] pix_y,
  output logic                  next_pixel
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, HOLD} state_t;
  localparam logic signed [32:0] LIM = 33'sd4 <<< (2 * FRAC_BITS);
  state_t state;
  logic signed [15:0] zr, zi, cr, ci, zr0, zi0;
  logic signed [31:0] rr, ii, ri, dx, dy;
  logic signed [32:0] mag, dif;
  logic signed [33:0] nr, ni;
  logic [7:0] cnt;
  logic esc;
  function automatic logic signed [15:0] fit(input logic signed [33:0] v);
`ifdef JULIA_SAT_EN
    return v > 34'sd32767 ? 16'sh7fff : v < -34'sd32768 ? 16'sh8000 : 16'(v);
`else
    return 16'(v);
`endif
  endfunction
  assign dx = 32'(pix_x) - 32'(X_OFFSET);
  assign dy = 32'(pix_y) - 32'(Y_OFFSET);
  assign zr0 = 16'(dx <<< (FRAC_BITS - STEP_SHIFT));
  assign zi0 = 16'(dy <<< (FRAC_BITS - STEP_SHIFT));
  assign rr = 32'(zr) * 32'(zr);
  assign ii = 32'(zi) * 32'(zi);
  assign ri = 32'(zr) * 32'(zi);
  assign mag = 33'(rr) + 33'(ii);
  assign dif = 33'(rr) - 33'(ii);
  assign esc = mag > LIM;
  assign nr = 34'(dif >>> FRAC_BITS) + 34'(cr);
  assign ni = 34'((33'(ri) <<< 1) >>> FRAC_BITS) + 34'(ci);
  assign busy = state != IDLE;
  assign iter_count = cnt;
  assign next_pixel = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      zr <= '0;
      zi <= '0;
      cr <= '0;
      ci <= '0;
      cnt <= '0;
      pix_x <= '0;
      pix_y <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pix_x <= x_value;
          pix_y <= y_value;
          cr <= c_re;
          ci <= c_im;
          state <= LOAD;
        end
        LOAD: begin
          zr <= zr0;
          zi <= zi0;
          cnt <= '0;
          state <= ITER;
        end
        ITER: if (esc || cnt == 8'(MAX_ITER)) state <= HOLD;
        else begin
          zr <= fit(nr);
          zi <= fit(ni);
          cnt <= cnt + 8'd1;
        end
        default: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end else out_valid <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_julia_iter.sv
// tb_julia_iter: random pixels and constants checked against a plain-arithmetic escape-time model.
module tb_julia_iter;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [9:0] x_value = 0, y_value = 0, pix_x, pix_y;
  logic [15:0] c_re = 0, c_im = 0;
  logic busy, out_valid, next_pixel;
  logic [7:0] iter_count;
  int total = 0, bad = 0, np_cnt = 0, done_cnt = 0;

  julia_iter dut (.clk(clk), .rst(rst), .start(start), .x_value(x_value), .y_value(y_value),
    .c_re(c_re), .c_im(c_im), .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
    .iter_count(iter_count), .pix_x(pix_x), .pix_y(pix_y), .next_pixel(next_pixel));

  always #5 clk = ~clk;
  always @(posedge clk) if (next_pixel) np_cnt++;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint fit(input longint v);
`ifdef JULIA_SAT_EN
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
`else
    return longint'(shortint'(v));
`endif
  endfunction

  // Escape count from the defining recurrence, in real-valued Q4.12 integers.
  function automatic int model(input int x, input int y, input int cre, input int cim);
    longint zr = (x - 320) * 16, zi = (y - 240) * 16, tr, ti;
    for (int n = 0; n < 255; n++) begin
      if (zr * zr + zi * zi > 4 * (longint'(1) << 24)) return n;
      tr = ((zr * zr - zi * zi) >>> 12) + cre;
      ti = ((2 * zr * zi) >>> 12) + cim;
      zr = fit(tr);
      zi = fit(ti);
    end
    return 255;
  endfunction

  task automatic pixel(input int x, input int y, input int cre, input int cim, input int stall, input bit poke);
    int cyc = 0, exp = model(x, y, cre, cim);
    @(negedge clk);
    start = 1; x_value = 10'(x); y_value = 10'(y); c_re = 16'(cre); c_im = 16'(cim);
    out_ready = stall == 0;
    @(posedge clk); #1 start = 0;
    chk("busy_run", busy, 1);
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1 cyc++;
    end
    chk("iter", iter_count, exp);
    chk("latency", cyc, exp + 3);
    chk("pix_x", pix_x, x);
    chk("pix_y", pix_y, y);
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 3) begin
        start = 1; x_value = 10'(x + 1); y_value = 10'(y + 1);
      end
      @(posedge clk); #1 start = 0;
      chk("hold_valid", out_valid, 1);
      chk("hold_iter", iter_count, exp);
      chk("hold_pix", {pix_x, pix_y}, {10'(x), 10'(y)});
      chk("hold_np", next_pixel, 0);
    end
    out_ready = 1; #1
    chk("np_pulse", next_pixel, 1);
    @(posedge clk); #1
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_np", next_pixel, 0);
    out_ready = 0;
    done_cnt++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_np", next_pixel, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_pix", {pix_x, pix_y}, 0);
    @(negedge clk) rst = 0;
    pixel(320, 240, 0, 0, 0, 0);
    pixel(0, 240, 0, 0, 0, 0);
    pixel(320, 240, 16'h7000, 16'h7000, 2, 0);
    pixel(100, 240, 0, 0, 10, 1);
    @(posedge clk); #1 chk("poke_ignored", busy, 0);
    pixel(0, 0, 0, 0, 0, 0);
    pixel(1023, 1023, -8192, 8192, 1, 0);
    // Reset while iterating: everything drops at once, no pulse, restart works.
    @(negedge clk);
    start = 1; x_value = 320; y_value = 240; c_re = 0; c_im = 0;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_np", next_pixel, 0);
    chk("arst_iter", iter_count, 0);
    chk("arst_pix", {pix_x, pix_y}, 0);
    @(negedge clk) rst = 0;
    repeat (3) @(posedge clk);
    #1 chk("arst_stay_idle", busy, 0);
    pixel(320, 240, 0, 0, 0, 0);
    for (int k = 0; k < 25; k++)
      pixel(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 16384)) - 8192, int'($urandom_range(0, 16384)) - 8192,
            int'($urandom_range(0, 3)), 0);
    chk("np_total", np_cnt, done_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
